// File: rtl/mips_pkg.sv
// mips_pkg: fetch-stage state encoding, instruction constants and branch-offset helper
package mips_pkg;
   localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES = 32'd4;
   localparam int          JUMP_IDX_W  = 26;
   localparam int          IMM16_W     = 16;

   typedef enum logic [1:0] {RST, REQ, VALID} fetch_state_t;

   // Sign-extended 16-bit immediate scaled to a byte offset
   function automatic logic [31:0] branch_offset(input logic [IMM16_W-1:0] imm);
      return {{(32-IMM16_W-2){imm[IMM16_W-1]}}, imm, 2'b00};
   endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ready bus between the fetch stage and memory
interface fetch_unit_if #(parameter int XLEN = 32);
   logic            req;
   logic [XLEN-1:0] addr;
   logic            ready;
   logic [XLEN-1:0] rdata;
   modport master (output req, addr, input ready, rdata);
   modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/next_pc_logic.sv
// next_pc_logic: sequential / branch / jump target selection for the held instruction
module next_pc_logic
   import mips_pkg::*;
#(
   parameter int XLEN = 32
)(
   input  logic [XLEN-1:0]       pc,
   input  logic [JUMP_IDX_W-1:0] instruct,
   input  logic                  branch,
   input  logic                  zero,
   input  logic                  jump,
   output logic [XLEN-1:0]       next_pc,
   output logic [XLEN-1:0]       pc_plus4
);
   assign pc_plus4 = pc + INSTR_BYTES;
   // jump outranks a taken branch; all sums wrap at 32 bits
   assign next_pc = jump             ? {pc_plus4[XLEN-1:XLEN-4], instruct, 2'b00} :
                    (branch && zero) ? pc_plus4 + branch_offset(instruct[IMM16_W-1:0]) :
                                       pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register and fetch FSM; optional perf counters via FETCH_PERF_CNT_EN
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int          XLEN     = 32
)(
   input  logic            clk,
   input  logic            reset,
   fetch_unit_if.master    imem,
   output logic [XLEN-1:0] instruct,
   output logic            instr_valid,
   input  logic            stall,
   input  logic            branch,
   input  logic            zero,
   input  logic            jump,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     fetch_count,
   output logic [31:0]     stall_cycles
`endif
);
   fetch_state_t    state, state_n;
   logic [XLEN-1:0] next_pc;
   logic            capture, retire;

   next_pc_logic #(.XLEN(XLEN)) u_next_pc (
      .pc       (pc),
      .instruct (instruct[JUMP_IDX_W-1:0]),
      .branch   (branch),
      .zero     (zero),
      .jump     (jump),
      .next_pc  (next_pc),
      .pc_plus4 (pc_plus4)
   );

   assign imem.req    = state == REQ;
   assign imem.addr   = pc;
   assign instr_valid = state == VALID;

   // Next state: capture on ready in REQ, retire on !stall in VALID
   always_comb begin
      capture = 1'b0;
      retire  = 1'b0;
      state_n = state;
      case (state)
         RST: state_n = REQ;
         REQ: begin
            capture = imem.ready;
            state_n = imem.ready ? VALID : REQ;
         end
         VALID: begin
            retire  = !stall;
            state_n = stall ? VALID : REQ;
         end
         default: state_n = RST;
      endcase
   end

   // State, captured instruction and PC; PC only moves when an instruction retires
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RST;
         pc       <= PC_RESET;
         instruct <= NOP_INSTR;
      end else begin
         state <= state_n;
         if (capture) instruct <= imem.rdata;
         if (retire) pc <= next_pc;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Retired instructions and cycles lost to memory wait or downstream stall
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count  <= '0;
         stall_cycles <= '0;
      end else begin
         if (retire) fetch_count <= fetch_count + 32'd1;
         if ((state == REQ && !imem.ready) || (state == VALID && stall))
            stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with an instruction-level reference model
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ready = 1'b0, stall = 1'b0, branch = 1'b0, zero = 1'b0, jump = 1'b0;
   logic [31:0] junk = 32'h0;
   logic [31:0] instruct, pc, pc_plus4, instruct_w, pc_w, pc_plus4_w;
   logic        instr_valid, instr_valid_w;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   fetch_unit_if bus();
   fetch_unit_if bus_w();

   // Program image: directed words at fixed addresses, hashed words elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      case (a)
         32'h0, 32'h4, 32'h8, 32'hC: return 32'h2008_0005;
         32'h10, 32'h3C, 32'h1000_0000: return 32'h0800_0010;
         32'h40: return 32'h1000_FFFE;
         32'h44: return 32'h0BFF_FFFF;
         default: begin
            h = a * 32'h9E37_79B1;
            return h ^ (h >> 13);
         end
      endcase
   endfunction

   function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w, input bit j, input bit b, input bit z);
      logic [31:0] seq;
      seq = p + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      if (b && z) return seq + 32'(int'($signed(w[15:0])) * 4);
      return seq;
   endfunction

   assign bus.ready   = ready;
   assign bus.rdata   = ready ? mem_word(bus.addr) : junk;
   assign bus_w.ready = 1'b1;
   assign bus_w.rdata = 32'h0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_cycles, fc_w, sc_w;
`endif

   fetch_unit #(.PC_RESET(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .imem(bus), .instruct(instruct), .instr_valid(instr_valid),
      .stall(stall), .branch(branch), .zero(zero), .jump(jump), .pc(pc), .pc_plus4(pc_plus4)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fetch_count), .stall_cycles(stall_cycles)
`endif
   );

   fetch_unit #(.PC_RESET(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .reset(reset), .imem(bus_w), .instruct(instruct_w), .instr_valid(instr_valid_w),
      .stall(1'b0), .branch(1'b0), .zero(1'b0), .jump(1'b0), .pc(pc_w), .pc_plus4(pc_plus4_w)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_count(fc_w), .stall_cycles(sc_w)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: instruction-level view (started / holding an instruction)
   logic [31:0] mpc = 32'h0, m_fc = 32'h0, m_sc = 32'h0;
   bit          m_started = 0, m_have = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mpc = 32'h0; m_started = 0; m_have = 0; m_fc = 0; m_sc = 0;
         exp_q.delete();
      end else if (!m_started) begin
         m_started = 1;
      end else if (!m_have) begin
         if (ready) begin
            m_have = 1;
            exp_q.push_back(mpc);
         end else m_sc = m_sc + 1;
      end else if (stall) begin
         m_sc = m_sc + 1;
      end else begin
         m_fc = m_fc + 1;
         mpc = ref_next(mpc, mem_word(mpc), jump, branch, zero);
         m_have = 0;
      end
   end

   // Monitor: per-cycle handshake checks and scoreboard pop on each new valid instruction
   bit prev_valid = 0;
   always @(negedge clk) begin
      logic [31:0] a;
      if (reset) prev_valid = 0;
      else begin
         chk("imem_req", {31'b0, bus.req}, {31'b0, m_started && !m_have});
         chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
         if (bus.req) chk("imem_addr", bus.addr, mpc);
         chk("pc", pc, mpc);
         chk("pc_plus4", pc_plus4, mpc + 32'd4);
`ifdef FETCH_PERF_CNT_EN
         chk("fetch_count", fetch_count, m_fc);
         chk("stall_cycles", stall_cycles, m_sc);
`endif
         if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_valid: got instruct %h with no expected fetch", instruct);
            end else begin
               a = exp_q.pop_front();
               chk("instruct", instruct, mem_word(a));
               chk("retire_pc", pc, a);
            end
         end
         prev_valid = instr_valid;
      end
   end

   task automatic run_instr(input int nwait, input int nstall, input bit b, input bit z, input bit j);
      repeat (nwait) begin
         ready = 1'b0; stall = 1'(($urandom) & 1); junk = $urandom;
         @(negedge clk);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'($urandom & 1); junk = $urandom;
      stall = 1'b1; branch = 1'b1; zero = 1'b1; jump = 1'($urandom & 1);
      repeat (nstall) @(negedge clk);
      stall = 1'b0; branch = b; zero = z; jump = j;
      @(negedge clk);
      ready = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
   endtask

   task automatic random_cycles(input int n);
      repeat (n) begin
         ready  = $urandom_range(0, 9) < 7;
         stall  = $urandom_range(0, 9) < 3;
         branch = 1'($urandom & 1);
         zero   = 1'($urandom & 1);
         jump   = $urandom_range(0, 3) == 0;
         junk   = $urandom;
         @(negedge clk);
      end
   endtask

   task automatic reset_state(input string tag);
      chk({tag, "_req"}, {31'b0, bus.req}, 32'h0);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
      chk({tag, "_pc"}, pc, 32'h0);
      chk({tag, "_instruct"}, instruct, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk({tag, "_fetch_count"}, fetch_count, 32'h0);
      chk({tag, "_stall_cycles"}, stall_cycles, 32'h0);
`endif
   endtask

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      reset_state("reset");
      reset = 1'b0; ready = 1'b1;
      @(negedge clk);
      chk("first_req", {31'b0, bus.req}, 32'h1);
      chk("first_addr", bus.addr, 32'h0);
      run_instr(0, 0, 0, 0, 0);
      chk("wrap_pc", pc_w, 32'hFFFF_FFFC);
      chk("wrap_pc_plus4", pc_plus4_w, 32'h0);
      run_instr(0, 0, 0, 0, 0);
      chk("wrap_to_zero", pc_w, 32'h0);
      run_instr(0, 0, 0, 0, 0);
      chk("seq_pc_c", pc, 32'hC);
      run_instr(5, 0, 0, 0, 0);
      chk("ready_wait_pc", pc, 32'h10);
      run_instr(0, 3, 0, 0, 1);
      chk("stall_then_jump", pc, 32'h40);
      run_instr(0, 0, 1, 1, 0);
      chk("branch_taken_back", pc, 32'h3C);
      run_instr(0, 0, 0, 0, 1);
      run_instr(0, 0, 1, 0, 0);
      chk("branch_not_taken", pc, 32'h44);
      run_instr(0, 0, 0, 0, 1);
      chk("jump_region_top", pc, 32'h0FFF_FFFC);
      run_instr(0, 0, 0, 0, 0);
      chk("seq_cross_region", pc, 32'h1000_0000);
      run_instr(0, 0, 1, 1, 1);
      chk("jump_beats_branch", pc, 32'h1000_0040);
      random_cycles(3000);
      guard = 0;
      ready = 1'b0;
      while (!(m_started && !m_have) && guard < 50) begin
         stall = 1'b0;
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         n_checks++; n_fail++;
         $display("FAIL reach_req: no fetch phase within %0d cycles", guard);
      end
      #2 reset = 1'b1;
      #1 reset_state("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      random_cycles(400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction decoder/controller. It holds the PC and issues requests to a variable-latency instruction memory through a req/ready handshake. It presents a registered 32-bit instruction word with a valid flag to the controller. It takes the controller's branch/jump decisions back in and computes the next PC from them.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
XLEN, 32, data/address width; fixed at 32 for the MIPS32 datapath.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  byte address of the fetch; equals pc.
imem_ready  input  1  memory accepts request and returns imem_rdata in the same cycle.
imem_rdata  input  32  instruction word; valid only when imem_req && imem_ready.
instruct  output  32  registered instruction word to the controller/datapath.
instr_valid  output  1  instruct holds a fetched instruction awaiting retirement.
stall  input  1  downstream not ready to retire the current instruction.
branch  input  1  controller branch signal for the current instruct.
zero  input  1  ALU zero flag for the current instruct.
jump  input  1  controller jump signal for the current instruct.
pc  output  32  address of the current instruct.
pc_plus4  output  32  pc + 4.

Behaviour:
- Reset is asynchronous and active-high: pc=PC_RESET, instruct=32'h0 (nop), instr_valid=0, imem_req=0, state=RST. Assertion mid-request aborts the request immediately, and no capture occurs.
- FSM states:
  - RST: imem_req=0; advance to REQ on the first clk edge with reset low.
  - REQ: imem_req=1, imem_addr=pc, held stable. On an edge with imem_ready=1: instruct<=imem_rdata, instr_valid<=1, go VALID. Otherwise stay in REQ (unbounded wait).
  - VALID: imem_req=0, instr_valid=1, instruct and pc held.
    - stall=1: hold indefinitely; branch/jump/zero are ignored.
    - stall=0: retire. pc<=next_pc, instr_valid<=0, go REQ.
- Latency: minimum 2 cycles per instruction (REQ with ready=1, then VALID with stall=0).
- next_pc, combinational from the held instruct:
  - jump=1: {pc_plus4[31:28], instruct[25:0], 2'b00}.
  - else branch&&zero: pc_plus4 + (sign_extend(instruct[15:0]) << 2), mod 2^32.
  - else: pc_plus4.
  - jump has priority over branch when both are asserted.
- All PC arithmetic wraps modulo 2^32. pc=32'hFFFF_FFFC sequential gives next_pc=32'h0.
- pc_plus4 = pc + 32'd4, combinational.
- imem_rdata is ignored outside REQ, and ignored in REQ when imem_ready=0.

Optional Feature:
- Macro FETCH_PERF_CNT_EN. When defined, adds two outputs:
  - fetch_count (32 bit): increments on each retire (VALID && !stall).
  - stall_cycles (32 bit): increments on every cycle in REQ with !imem_ready, and every cycle in VALID with stall=1.
- Both counters reset to 0, wrap on overflow, and update in the same cycle as the triggering event.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - fetch state enum {RST, REQ, VALID}, 2-bit encoding.
  - constants NOP_INSTR=32'h0, INSTR_BYTES=4, JUMP_IDX field widths (26), IMM16 width (16).
- One natural sub-module, next_pc_logic: purely combinational. Inputs pc, instruct, branch, zero, jump. Outputs next_pc and pc_plus4.
- fetch_unit holds the FSM and registers.

Test Plan:
- Reset release, imem_ready tied 1, imem_rdata=32'h2008_0005, stall=0 → imem_addr=0 in cycle 1, instr_valid=1 in cycle 2, pc steps 0,4,8 every 2 cycles.
- imem_ready held 0 for 5 cycles in REQ → imem_req and imem_addr stay constant, instr_valid=0. Ready on cycle 6 captures the word.
- VALID with stall=1 for 3 cycles, branch=1, zero=1 → pc and instruct unchanged, no new imem_req. stall=0 then retires.
- pc=32'h40, instruct=32'h1000_FFFE, branch=1, zero=1 → next fetch address 32'h3C. Same with zero=0 → 32'h44.
- pc=32'h1000_0000, instruct=32'h0800_0010, jump=1, branch=1, zero=1 → next address 32'h1000_0040 (jump wins).
- reset asserted mid-REQ → imem_req=0 asynchronously, pc=PC_RESET, instr_valid=0. With FETCH_PERF_CNT_EN defined, both counters read 0.
